tensor_tile_sequencer: RTL
==========================

Name: tensor_tile_sequencer

Overview:
- Operand-side counterpart of the tensor DPU. Collects one HMMA octet's operands from a 128-bit operand stream, 8 beats per tile, into A (4x2), B (2x4) and C (4x4) tiles of 32-bit words.
- Issues each assembled tile to the DPU with valid/ready and the warp id.
- Accepts D tiles back from the DPU and serializes them into 4 row-sized writeback beats toward the register file.
- Sits between the operand collector and the DPU, bounding DPU occupancy.

Parameters:
- NW_WIDTH, default `NW_WIDTH, warp id width.
- MAX_INFLIGHT, default 4, maximum tiles issued to the DPU whose D tile has not yet been captured.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- op_valid  in  1  operand beat valid
- op_ready  out  1  operand beat accepted
- op_data  in  128  four 32-bit words; lane k = bits [32k+31:32k]
- op_wid  in  NW_WIDTH  warp id of beat
- dpu_valid_in  out  1  tile valid to DPU
- dpu_ready_in  in  1  DPU accepts tile
- dpu_A_tile  out  256  [3:0][1:0][31:0]
- dpu_B_tile  out  256  [1:0][3:0][31:0]
- dpu_C_tile  out  512  [3:0][3:0][31:0]
- dpu_wid  out  NW_WIDTH  warp id of issued tile
- dpu_valid_out  in  1  D tile valid from DPU
- dpu_ready_out  out  1  sequencer accepts D tile
- dpu_D_tile  in  512  [3:0][3:0][31:0]
- dpu_D_wid  in  NW_WIDTH  warp id of D tile
- wb_valid  out  1  writeback beat valid
- wb_ready  in  1  writeback beat accepted
- wb_data  out  128  one D row, lane k = D[row][k]
- wb_row  out  2  D row index
- wb_wid  out  NW_WIDTH  warp id
- wb_last  out  1  high on row 3
- busy  out  1  any tile collecting, pending, in flight or draining
- err  out  1  sticky protocol error

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - While reset=0: all state cleared; op_ready=0, dpu_ready_out=0, and all other outputs 0.
  - First cycle after deassert: op_ready=1, dpu_ready_out=1.
- Beat map (beat_cnt 0..7):
  - 0: A[0][0],A[0][1],A[1][0],A[1][1]
  - 1: A[2][0],A[2][1],A[3][0],A[3][1]
  - 2: B[0][0..3]
  - 3: B[1][0..3]
  - 4..7: C[0..3][0..3]
- Collect FSM:
  - COLLECT: op_ready=1. On op fire, write the beat and increment beat_cnt. Beat 0 latches op_wid as tile wid. Firing beat 7 moves to ISSUE and resets beat_cnt to 0.
  - ISSUE: op_ready=0. dpu_valid_in = (inflight < MAX_INFLIGHT). Tile registers and dpu_wid are held stable. On dpu_valid_in && dpu_ready_in, return to COLLECT.
  - Minimum issue interval is 9 cycles.
- inflight counter, width clog2(MAX_INFLIGHT+1):
  - +1 on DPU issue fire; -1 on D capture; unchanged when both occur in the same cycle.
  - Capture at inflight=0 sets err; the counter holds at 0.
- Drain FSM:
  - IDLE: dpu_ready_out=1. On dpu_valid_out fire, capture dpu_D_tile and dpu_D_wid, set row=0, go to DRAIN.
  - DRAIN: dpu_ready_out=0; wb_valid=1; wb_data=D[row]; wb_row=row; wb_wid=captured wid; wb_last=(row==3). Outputs hold stable while wb_ready=0. On fire, row++; firing row 3 returns to IDLE.
  - No bubble required between the D capture and the first wb beat (next cycle).
- Collect and drain FSMs run concurrently and independently.
- err: set when op fires at beat_cnt≠0 with op_wid≠latched wid (beat still accepted), or on inflight underflow. Cleared only by reset.
- busy = (collect≠COLLECT) | (beat_cnt≠0) | (inflight≠0) | (drain≠IDLE). Combinational from state.
- Reset mid-operation: partial tile, pending issue, inflight count and drain buffer are discarded; no further dpu_valid_in or wb_valid until new beats arrive.

Test Plan:
- Single tile (DPU model, 3-cycle latency), wid=2, beat words 0x100+n, then D rows 0xD0..0xD3 replicated → dpu_A_tile[1][1]=0x103, dpu_B_tile[1][0]=0x10C, dpu_C_tile[3][3]=0x11F, dpu_wid=2; 4 wb beats, wb_row 0..3, wb_last only on row 3, wb_wid=2, busy falls after the last beat.
- MAX_INFLIGHT=4 with dpu_valid_out held 0, five tiles sent → four issue fires; fifth tile sits in ISSUE with dpu_valid_in=0 and op_ready=0; one D capture → fifth issues the next cycle.
- wb_ready=0 for 5 cycles at row 2 → wb_data/wb_row stable at row 2, dpu_ready_out=0, a DPU D tile waits; release → rows 2,3 then immediate capture.
- op_wid changes from 1 to 3 on beat 3 → err=1 the next cycle and stays 1 through later clean tiles until reset.
- Reset asserted after beat 5 and during DRAIN row 1 → op_ready=0 during reset; afterwards op_ready=1, beat_cnt=0, wb_valid=0, inflight=0, busy=0, no spurious dpu_valid_in.
- Issue fire and D capture in the same cycle at inflight=2 → inflight stays 2; err stays 0.

Source files
------------

// File: rtl/tensor_tile_sequencer.sv
// Operand-side tile sequencer for the tensor DPU: gathers A/B/C tiles from a 128-bit operand
// stream, issues them to the DPU and serializes returned D tiles into row writeback beats.
`ifndef NW_WIDTH
`define NW_WIDTH 4
`endif

module tensor_tile_sequencer #(
   parameter int unsigned NW_WIDTH     = `NW_WIDTH,
   parameter int unsigned MAX_INFLIGHT = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        op_valid,
   output logic                        op_ready,
   input  logic [127:0]                op_data,
   input  logic [NW_WIDTH-1:0]         op_wid,
   output logic                        dpu_valid_in,
   input  logic                        dpu_ready_in,
   output logic [3:0][1:0][31:0]       dpu_A_tile,
   output logic [1:0][3:0][31:0]       dpu_B_tile,
   output logic [3:0][3:0][31:0]       dpu_C_tile,
   output logic [NW_WIDTH-1:0]         dpu_wid,
   input  logic                        dpu_valid_out,
   output logic                        dpu_ready_out,
   input  logic [3:0][3:0][31:0]       dpu_D_tile,
   input  logic [NW_WIDTH-1:0]         dpu_D_wid,
   output logic                        wb_valid,
   input  logic                        wb_ready,
   output logic [127:0]                wb_data,
   output logic [1:0]                  wb_row,
   output logic [NW_WIDTH-1:0]         wb_wid,
   output logic                        wb_last,
   output logic                        busy,
   output logic                        err
);

   localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);

   typedef enum logic {StCollect, StIssue} collect_e;
   typedef enum logic {StIdle, StDrain}    drain_e;

   // Held low through reset so the handshakes only open on the first clock after release.
   logic                  up_q;
   collect_e              collect_q;
   logic [2:0]            beat_cnt_q;
   logic [NW_WIDTH-1:0]   tile_wid_q;
   logic [3:0][1:0][31:0] a_q;
   logic [1:0][3:0][31:0] b_q;
   logic [3:0][3:0][31:0] c_q;
   logic [IW-1:0]         inflight_q;
   drain_e                drain_q;
   logic [1:0]            row_q;
   logic [3:0][3:0][31:0] d_q;
   logic [NW_WIDTH-1:0]   d_wid_q;
   logic                  err_q;

   logic op_fire, issue_fire, cap_fire, wb_fire;

   assign op_ready      = up_q & (collect_q == StCollect);
   assign dpu_valid_in  = (collect_q == StIssue) & (inflight_q < IW'(MAX_INFLIGHT));
   assign dpu_ready_out = up_q & (drain_q == StIdle);
   assign wb_valid      = (drain_q == StDrain);

   assign op_fire    = op_valid & op_ready;
   assign issue_fire = dpu_valid_in & dpu_ready_in;
   assign cap_fire   = dpu_valid_out & dpu_ready_out;
   assign wb_fire    = wb_valid & wb_ready;

   assign dpu_A_tile = a_q;
   assign dpu_B_tile = b_q;
   assign dpu_C_tile = c_q;
   assign dpu_wid    = tile_wid_q;

   assign wb_data = d_q[row_q];
   assign wb_row  = row_q;
   assign wb_wid  = d_wid_q;
   assign wb_last = wb_valid & (row_q == 2'd3);

   assign busy = (collect_q != StCollect) | (beat_cnt_q != 3'd0) | (inflight_q != '0) |
                 (drain_q != StIdle);
   assign err  = err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         up_q       <= 1'b0;
         collect_q  <= StCollect;
         beat_cnt_q <= 3'd0;
         tile_wid_q <= '0;
         a_q        <= '0;
         b_q        <= '0;
         c_q        <= '0;
      end else begin
         up_q <= 1'b1;
         case (collect_q)
            StCollect: begin
               if (op_fire) begin
                  case (beat_cnt_q)
                     3'd0: begin
                        a_q[0]     <= op_data[63:0];
                        a_q[1]     <= op_data[127:64];
                        tile_wid_q <= op_wid;
                     end
                     3'd1: begin
                        a_q[2] <= op_data[63:0];
                        a_q[3] <= op_data[127:64];
                     end
                     3'd2:    b_q[0] <= op_data;
                     3'd3:    b_q[1] <= op_data;
                     default: c_q[beat_cnt_q[1:0]] <= op_data;
                  endcase
                  // Wraps 7 -> 0 as the tile completes.
                  beat_cnt_q <= beat_cnt_q + 3'd1;
                  if (beat_cnt_q == 3'd7) collect_q <= StIssue;
               end
            end
            StIssue: begin
               if (issue_fire) collect_q <= StCollect;
            end
            default: collect_q <= StCollect;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inflight_q <= '0;
         err_q      <= 1'b0;
      end else begin
         if (issue_fire && !cap_fire) begin
            inflight_q <= inflight_q + IW'(1);
         end else if (cap_fire && !issue_fire && (inflight_q != '0)) begin
            inflight_q <= inflight_q - IW'(1);
         end
         if ((op_fire && (beat_cnt_q != 3'd0) && (op_wid != tile_wid_q)) ||
             (cap_fire && (inflight_q == '0))) begin
            err_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drain_q <= StIdle;
         row_q   <= 2'd0;
         d_q     <= '0;
         d_wid_q <= '0;
      end else begin
         case (drain_q)
            StIdle: begin
               if (cap_fire) begin
                  d_q     <= dpu_D_tile;
                  d_wid_q <= dpu_D_wid;
                  row_q   <= 2'd0;
                  drain_q <= StDrain;
               end
            end
            StDrain: begin
               if (wb_fire) begin
                  row_q <= row_q + 2'd1;
                  if (row_q == 2'd3) drain_q <= StIdle;
               end
            end
            default: drain_q <= StIdle;
         endcase
      end
   end

endmodule
